// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and main_memory signals around the unified memory port arbiter.
// The master modport is the arbiter's view; slave is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  // Fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_stall;
  logic              i_valid;
  logic [ADDR_W-1:0] i_rdata;

  // Data port
  logic              d_req;
  logic              d_rnw;
  logic [ADDR_W-1:0] d_addr;
  logic [ADDR_W-1:0] d_wdata;
  logic [1:0]        d_store_size;
  logic              d_gnt;
  logic              d_stall;
  logic              d_valid;
  logic [ADDR_W-1:0] d_rdata;

  // main_memory port
  logic              mem_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [ADDR_W-1:0] mem_data_in;
  logic              mem_read_not_write;
  logic [1:0]        mem_access_size;
  logic [1:0]        mem_store_size;
  logic [ADDR_W-1:0] mem_data_out;

  modport master (
    input  i_req, i_addr,
    output i_gnt, i_stall, i_valid, i_rdata,
    input  d_req, d_rnw, d_addr, d_wdata, d_store_size,
    output d_gnt, d_stall, d_valid, d_rdata,
    output mem_enable, mem_address, mem_data_in, mem_read_not_write,
    output mem_access_size, mem_store_size,
    input  mem_data_out
  );

  modport slave (
    output i_req, i_addr,
    input  i_gnt, i_stall, i_valid, i_rdata,
    output d_req, d_rnw, d_addr, d_wdata, d_store_size,
    input  d_gnt, d_stall, d_valid, d_rdata,
    input  mem_enable, mem_address, mem_data_in, mem_read_not_write,
    input  mem_access_size, mem_store_size,
    output mem_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported main_memory between fetch and data stages and steers the
// one-cycle-latency read data back to whichever side owned the previous cycle's access.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must lie in 1..15");
  end

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StInsn = 2'd1,
    StData = 2'd2
  } owner_e;

  owner_e      r_owner;
  owner_e      w_owner_next;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_cnt_next;

  logic        w_starved;
  logic        w_i_gnt;
  logic        w_d_gnt;
  logic        w_d_store;

  // Grant: data wins ties unless fetch has waited MAX_WAIT consecutive cycles.
  always_comb begin
    w_starved = (r_starve_cnt == MaxWait);
    w_i_gnt   = bus.i_req & (~bus.d_req | w_starved);
    w_d_gnt   = bus.d_req & (~bus.i_req | ~w_starved);
    w_d_store = w_d_gnt & ~bus.d_rnw;
  end

  always_comb begin
    w_starve_cnt_next = 4'd0;
    if (bus.i_req && !w_i_gnt) begin
      w_starve_cnt_next = w_starved ? r_starve_cnt : r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= 4'd0;
    end else begin
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  // Owner FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= StIdle;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  // Owner FSM: next state, one access per cycle so any state may follow any state
  always_comb begin
    w_owner_next = StIdle;
    if (w_i_gnt) begin
      w_owner_next = StInsn;
    end else if (w_d_gnt) begin
      w_owner_next = StData;
    end
  end

  // Owner FSM: return-path outputs
  always_comb begin
    bus.i_valid = 1'b0;
    bus.i_rdata = '0;
    bus.d_valid = 1'b0;
    bus.d_rdata = '0;
    unique case (r_owner)
      StInsn: begin
        bus.i_valid = 1'b1;
        bus.i_rdata = bus.mem_data_out;
      end
      StData: begin
        bus.d_valid = 1'b1;
        bus.d_rdata = bus.mem_data_out;
      end
      default: ;
    endcase
  end

  // Requester-side handshake
  always_comb begin
    bus.i_gnt   = w_i_gnt;
    bus.i_stall = bus.i_req & ~w_i_gnt;
    bus.d_gnt   = w_d_gnt;
    bus.d_stall = bus.d_req & ~w_d_gnt;
  end

  // Memory-side request mux; idle cycles present a quiet read with zeroed fields
  always_comb begin
    bus.mem_enable         = w_i_gnt | w_d_gnt;
    bus.mem_address        = '0;
    bus.mem_data_in        = '0;
    bus.mem_store_size     = 2'b00;
    bus.mem_access_size    = 2'b00;
    bus.mem_read_not_write = ~w_d_store;
    if (w_i_gnt) begin
      bus.mem_address = bus.i_addr;
    end else if (w_d_gnt) begin
      bus.mem_address    = bus.d_addr;
      bus.mem_data_in    = bus.d_wdata;
      bus.mem_store_size = bus.d_store_size;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;

  localparam int unsigned AddrW   = 32;
  localparam int unsigned MaxWait = 4;
  localparam logic [31:0] MemKey  = 32'h5A5A_0F0F;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_port_arbiter_if #(.ADDR_W(AddrW)) bus ();

  mem_port_arbiter #(
    .ADDR_W   (AddrW),
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reads return address ^ MemKey one cycle later; writes return all-ones.
  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_read_not_write) begin
      bus.mem_data_out <= bus.mem_address ^ MemKey;
    end else begin
      bus.mem_data_out <= 32'hFFFF_FFFF;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.i_req = 1'b1;
    bus.i_addr = 32'h8002_0000;
    bus.d_req = 1'b0;
    bus.d_rnw = 1'b1;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.d_store_size = 2'b00;

    // Reset held with a pending fetch
    repeat (2) @(negedge clk);
    check("rst_i_valid", 32'(bus.i_valid), 32'd0);
    check("rst_d_valid", 32'(bus.d_valid), 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'd0);
    check("rst_starve", 32'(dut.r_starve_cnt), 32'd0);
    check("rst_i_gnt_comb", 32'(bus.i_gnt), 32'd1);
    check("access_size", 32'(bus.mem_access_size), 32'd0);

    // Release; first fetch
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rel_addr", bus.mem_address, 32'h8002_0000);
    check("rel_en", 32'(bus.mem_enable), 32'd1);
    next_cycle();
    bus.i_req = 1'b0;  // dropping req in the return cycle must not lose the return
    @(negedge clk);
    check("rel_i_valid", 32'(bus.i_valid), 32'd1);
    check("rel_i_rdata", bus.i_rdata, 32'h8002_0000 ^ MemKey);

    // Fetch stream, 8 back-to-back
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      bus.i_req = 1'b1;
      bus.i_addr = 32'h0000_4000 + 32'(4 * k);
      @(negedge clk);
      check("fs_gnt", 32'(bus.i_gnt), 32'd1);
      check("fs_stall", 32'(bus.i_stall), 32'd0);
      check("fs_valid", 32'(bus.i_valid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) check("fs_rdata", bus.i_rdata, (32'h0000_4000 + 32'(4 * (k - 1))) ^ MemKey);
    end
    next_cycle();
    bus.i_req = 1'b0;
    @(negedge clk);
    check("fs_last_valid", 32'(bus.i_valid), 32'd1);
    check("fs_last_rdata", bus.i_rdata, 32'h0000_401C ^ MemKey);
    check("idle_en", 32'(bus.mem_enable), 32'd0);
    check("idle_rnw", 32'(bus.mem_read_not_write), 32'd1);

    // Data priority
    next_cycle();
    bus.i_req = 1'b1;
    bus.i_addr = 32'h0000_5000;
    bus.d_req = 1'b1;
    bus.d_rnw = 1'b1;
    bus.d_addr = 32'h0000_0100;
    @(negedge clk);
    check("dp_d_gnt", 32'(bus.d_gnt), 32'd1);
    check("dp_i_gnt", 32'(bus.i_gnt), 32'd0);
    check("dp_i_stall", 32'(bus.i_stall), 32'd1);
    check("dp_addr", bus.mem_address, 32'h0000_0100);
    next_cycle();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    check("dp_d_valid", 32'(bus.d_valid), 32'd1);
    check("dp_d_rdata", bus.d_rdata, 32'h0000_0100 ^ MemKey);
    check("dp_i_valid", 32'(bus.i_valid), 32'd0);

    // Starvation: d cycles 1-4, i cycle 5, d cycles 6-9
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      bus.i_req = 1'b1;
      bus.i_addr = 32'h0000_1000;
      bus.d_req = 1'b1;
      bus.d_addr = 32'h0000_0200;
      @(negedge clk);
      check("sv_i_gnt", 32'(bus.i_gnt), (c == 5) ? 32'd1 : 32'd0);
      check("sv_d_gnt", 32'(bus.d_gnt), (c == 5) ? 32'd0 : 32'd1);
      check("sv_d_stall", 32'(bus.d_stall), (c == 5) ? 32'd1 : 32'd0);
      if (c > 1) begin
        check("sv_i_valid", 32'(bus.i_valid), (c == 6) ? 32'd1 : 32'd0);
        check("sv_d_valid", 32'(bus.d_valid), (c == 6) ? 32'd0 : 32'd1);
      end
      if (c == 6) check("sv_i_rdata", bus.i_rdata, 32'h0000_1000 ^ MemKey);
    end
    next_cycle();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    check("sv_tail_d_valid", 32'(bus.d_valid), 32'd1);
    check("sv_tail_d_rdata", bus.d_rdata, 32'h0000_0200 ^ MemKey);

    // Store
    next_cycle();
    bus.d_req = 1'b1;
    bus.d_rnw = 1'b0;
    bus.d_addr = 32'h0000_0300;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_store_size = 2'b01;
    @(negedge clk);
    check("st_rnw", 32'(bus.mem_read_not_write), 32'd0);
    check("st_data_in", bus.mem_data_in, 32'hDEAD_BEEF);
    check("st_size", 32'(bus.mem_store_size), 32'd1);
    check("st_addr", bus.mem_address, 32'h0000_0300);
    next_cycle();
    bus.d_req = 1'b0;
    bus.d_rnw = 1'b1;
    @(negedge clk);
    check("st_d_valid", 32'(bus.d_valid), 32'd1);
    check("st_idle_data_in", bus.mem_data_in, 32'd0);
    check("st_idle_size", 32'(bus.mem_store_size), 32'd0);

    // Async reset kills a return already on the outputs
    next_cycle();
    bus.i_req = 1'b1;
    bus.i_addr = 32'h0000_6000;
    @(negedge clk);
    check("ar1_gnt", 32'(bus.i_gnt), 32'd1);
    next_cycle();
    bus.i_req = 1'b0;
    check("ar1_valid_pre", 32'(bus.i_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("ar1_valid_async", 32'(bus.i_valid), 32'd0);
    next_cycle();
    rst = 1'b1;

    // Async reset between grant and return edge
    next_cycle();
    bus.i_req = 1'b1;
    bus.i_addr = 32'h0000_7000;
    @(negedge clk);
    check("ar2_gnt", 32'(bus.i_gnt), 32'd1);
    #1;
    rst = 1'b0;
    bus.i_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("ar2_i_valid", 32'(bus.i_valid), 32'd0);
    check("ar2_owner", 32'(dut.r_owner), 32'd0);
    next_cycle();
    @(negedge clk);
    check("ar2_i_valid_late", 32'(bus.i_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified main_memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Grants at most one requester per cycle. Data side has fixed priority; a saturating counter prevents fetch starvation.
- Tracks the one-cycle read latency of main_memory and steers read data back to the owning requester with a valid pulse.
- Produces the per-port stall signals consumed by the pipeline's hazard logic.

Parameters:
- ADDR_W, 32, address and data width.
- MAX_WAIT, 4, consecutive denied cycles after which a pending fetch request overrides data priority (range 1..15).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- i_req  in  1  fetch read request.
- i_addr  in  ADDR_W  fetch address (PC).
- i_gnt  out  1  fetch granted this cycle (combinational).
- i_stall  out  1  = i_req & ~i_gnt.
- i_valid  out  1  pulse: i_rdata valid.
- i_rdata  out  ADDR_W  instruction word.
- d_req  in  1  data request.
- d_rnw  in  1  1 = load, 0 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  ADDR_W  store data.
- d_store_size  in  2  store size code, passed through.
- d_gnt  out  1  data granted this cycle (combinational).
- d_stall  out  1  = d_req & ~d_gnt.
- d_valid  out  1  pulse one cycle after any data grant (load data or store completion).
- d_rdata  out  ADDR_W  load data; meaningful only when the completed access was a load.
- mem_enable  out  1  = i_gnt | d_gnt.
- mem_address  out  ADDR_W  granted address; 0 when no grant.
- mem_data_in  out  ADDR_W  d_wdata on data grant, else 0.
- mem_read_not_write  out  1  1 on fetch grant or data load grant, 0 on data store grant, 1 when idle.
- mem_access_size  out  2  constant 2'b00 (one word).
- mem_store_size  out  2  d_store_size on data grant, else 2'b00.
- mem_data_out  in  ADDR_W  memory read data, valid the cycle after an enabled read.

Behaviour:
- Grant, combinational from current inputs and state:
  - d_req only -> d_gnt.
  - i_req only -> i_gnt.
  - Both, starve_cnt < MAX_WAIT -> d_gnt.
  - Both, starve_cnt == MAX_WAIT -> i_gnt.
  - i_gnt and d_gnt are never both 1.
- starve_cnt (4 bits):
  - Increments when i_req & ~i_gnt; saturates at MAX_WAIT.
  - Clears to 0 when i_gnt or ~i_req.
- In-flight owner FSM, one register updated every cycle:
  - IDLE: no grant in the previous cycle.
  - INSN: fetch granted in the previous cycle.
  - DATA: data granted in the previous cycle.
  - Next state = INSN if i_gnt, DATA if d_gnt, else IDLE. Any state can go to any state; back-to-back grants are fully pipelined, throughput 1 access/cycle.
- Return path:
  - In INSN: i_valid=1, i_rdata=mem_data_out.
  - In DATA: d_valid=1, d_rdata=mem_data_out.
  - Otherwise valids are 0 and rdata outputs are 0.
- Latency: grant in cycle N -> valid in cycle N+1, no bubbles.
- Reset (rst=0), asynchronous: owner=IDLE, starve_cnt=0, so i_valid=d_valid=0 and rdata=0. Combinational grant/stall outputs still follow inputs.
- Reset mid-operation: a pending in-flight read is discarded and produces no valid pulse after reset release.
- A requester dropping req in the cycle its valid returns has no effect; the return is still delivered.
- Stores: mem_read_not_write=0. d_valid still pulses in N+1 and d_rdata carries whatever mem_data_out returns; the consumer ignores it.

Test Plan:
- Reset: hold rst=0 with i_req=1 -> i_valid=d_valid=0, starve_cnt=0. Release; i_addr=0x80020000 -> mem_address=0x80020000, mem_enable=1, i_valid next cycle with i_rdata=mem_data_out.
- Single fetch stream: i_req=1 for 8 cycles, addresses +4 each -> i_gnt every cycle, i_valid in cycles 2..9, i_stall=0 throughout.
- Data priority: i_req=d_req=1, d_rnw=1, d_addr=0x100 -> d_gnt=1, i_stall=1, mem_address=0x100; d_valid next cycle, i_valid=0.
- Starvation: i_req=d_req=1 held, MAX_WAIT=4 -> d_gnt cycles 1-4, i_gnt cycle 5 (d_stall=1), starve_cnt back to 0, then d_gnt cycles 6-9.
- Store: d_req=1, d_rnw=0, d_wdata=0xDEADBEEF, d_store_size=2'b01 -> mem_read_not_write=0, mem_data_in=0xDEADBEEF, mem_store_size=2'b01; d_valid pulses next cycle.
- Async reset mid-read: fetch granted, rst=0 asynchronously before the next edge -> i_valid never pulses for that access; owner=IDLE after release.
